// File: rtl/mux8_arb_pkg.sv
// Shared constants and state encoding for the 8-way round-robin select arbiter.
package mux8_arb_pkg;

    localparam int NREQ  = 8;
    localparam int SEL_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_OWN    = 2'd1,
        ST_SWITCH = 2'd2
    } state_t;

endpackage

// File: rtl/rr_pick8.sv
// Rotating-priority picker: the search starts at last+1 and wraps, so `last` is searched last.
module rr_pick8
    import mux8_arb_pkg::*;
(
    input  logic [NREQ-1:0]  req,
    input  logic [SEL_W-1:0] last,
    output logic             found,
    output logic [SEL_W-1:0] idx
);

    logic [SEL_W-1:0] base;
    logic [SEL_W-1:0] src [NREQ];
    logic [NREQ-1:0]  rot;
    logic [SEL_W-1:0] offset;

    assign base = last + SEL_W'(1);

    // rot[0] is the highest-priority requester; the 3-bit sum wraps 7->0.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_rot
            assign src[gi] = base + SEL_W'(gi);
            assign rot[gi] = req[src[gi]];
        end
    endgenerate

    always_comb begin
        found  = 1'b0;
        offset = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                found  = 1'b1;
                offset = SEL_W'(i);
            end
        end
    end

    assign idx = offset + base;

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin owner arbiter for the shared 8-to-1 select path, with hold timeout
// and a single dead cycle between consecutive owners.
module mux8_rr_arbiter
    import mux8_arb_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NREQ-1:0]  req,
    input  logic             rel,
    output logic [NREQ-1:0]  gnt,
    output logic [SEL_W-1:0] sel,
    output logic             busy,
    output logic             timeout
);

    state_t           state_reg, state_next;
    logic [NREQ-1:0]  gnt_reg, gnt_next;
    logic [SEL_W-1:0] sel_reg, sel_next;
    logic [SEL_W-1:0] last_reg, last_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             busy_reg, busy_next;
    logic             timeout_reg, timeout_next;

    logic             pick_found;
    logic [SEL_W-1:0] pick_idx;
    logic             hold_done;

    rr_pick8 u_pick (
        .req   (req),
        .last  (last_reg),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign hold_done = (cnt_reg == CNT_W'(MAX_HOLD - 1));

    always_comb begin
        state_next   = state_reg;
        gnt_next     = gnt_reg;
        sel_next     = sel_reg;
        last_next    = last_reg;
        cnt_next     = cnt_reg;
        busy_next    = busy_reg;
        timeout_next = 1'b0;
        case (state_reg)
            ST_OWN: begin
                // last_reg always equals the current owner while in OWN.
                if (rel || !req[last_reg] || hold_done) begin
                    state_next   = ST_SWITCH;
                    gnt_next     = '0;
                    busy_next    = 1'b0;
                    timeout_next = !rel && req[last_reg];
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            default: begin
                if (pick_found) begin
                    state_next = ST_OWN;
                    gnt_next   = {{(NREQ-1){1'b0}}, 1'b1} << pick_idx;
                    sel_next   = pick_idx;
                    last_next  = pick_idx;
                    cnt_next   = '0;
                    busy_next  = 1'b1;
                end else begin
                    state_next = ST_IDLE;
                    gnt_next   = '0;
                    busy_next  = 1'b0;
                end
            end
        endcase
    end

    // last resets to 7 so the very first search begins at requester 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            gnt_reg     <= '0;
            sel_reg     <= '0;
            last_reg    <= SEL_W'(NREQ - 1);
            cnt_reg     <= '0;
            busy_reg    <= 1'b0;
            timeout_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            gnt_reg     <= gnt_next;
            sel_reg     <= sel_next;
            last_reg    <= last_next;
            cnt_reg     <= cnt_next;
            busy_reg    <= busy_next;
            timeout_reg <= timeout_next;
        end
    end

    assign gnt     = gnt_reg;
    assign sel     = sel_reg;
    assign busy    = busy_reg;
    assign timeout = timeout_reg;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Directed bench for mux8_rr_arbiter: a reference model pushes expected outputs
// to a scoreboard each cycle, which is popped and compared after the clock edge.
module tb_mux8_rr_arbiter;

    localparam int MAX_HOLD = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req = 8'h00;
    logic       rel = 1'b0;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       busy;
    logic       timeout;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [7:0] gnt;
        logic [2:0] sel;
        logic       busy;
        logic       to;
    } exp_t;

    exp_t sb[$];

    // reference model state
    int         m_state;   // 0 idle, 1 own, 2 switch
    logic [7:0] m_gnt;
    logic [2:0] m_sel;
    logic [2:0] m_last;
    int         m_cnt;
    logic       m_busy;
    logic       m_to;

    mux8_rr_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(5)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .rel     (rel),
        .gnt     (gnt),
        .sel     (sel),
        .busy    (busy),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_gnt = 8'h00; m_sel = 3'd0; m_last = 3'd7;
        m_cnt = 0; m_busy = 1'b0; m_to = 1'b0;
    endtask

    // Drive one cycle of inputs, advance the model, and check the DUT after the edge.
    task automatic cycle(input logic r, input logic [7:0] q);
        exp_t       e;
        exp_t       got;
        logic       f;
        logic [2:0] w;
        rel = r;
        req = q;
        f = 1'b0;
        w = 3'd0;
        for (int k = 1; k <= 8; k++) begin
            if (!f && q[(int'(m_last) + k) % 8]) begin
                f = 1'b1;
                w = 3'((int'(m_last) + k) % 8);
            end
        end
        m_to = 1'b0;
        if (m_state == 1) begin
            if (r) begin
                m_state = 2; m_gnt = 8'h00; m_busy = 1'b0;
            end else if (!q[m_sel]) begin
                m_state = 2; m_gnt = 8'h00; m_busy = 1'b0;
            end else if (m_cnt == MAX_HOLD - 1) begin
                m_state = 2; m_gnt = 8'h00; m_busy = 1'b0; m_to = 1'b1;
            end else begin
                m_cnt++;
            end
        end else if (f) begin
            m_state = 1; m_gnt = 8'h01 << w; m_sel = w; m_last = w;
            m_cnt = 0; m_busy = 1'b1;
        end else begin
            m_state = 0; m_gnt = 8'h00; m_busy = 1'b0;
        end
        e.gnt = m_gnt; e.sel = m_sel; e.busy = m_busy; e.to = m_to;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk("sb_underflow", 8'h00, 8'h01);
        end else begin
            got = sb.pop_front();
            chk("gnt", gnt, got.gnt);
            chk("sel", {5'd0, sel}, {5'd0, got.sel});
            chk("busy", {7'd0, busy}, {7'd0, got.busy});
            chk("timeout", {7'd0, timeout}, {7'd0, got.to});
        end
        $display("cycle t=%0t rel=%b req=%h -> gnt=%h sel=%0d busy=%b timeout=%b",
                 $time, r, q, gnt, sel, busy, timeout);
    endtask

    initial begin
        int hold;
        int exp_idx;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_gnt", gnt, 8'h00);
        chk("rst_sel", {5'd0, sel}, 8'h00);
        chk("rst_busy", {7'd0, busy}, 8'h00);
        chk("rst_timeout", {7'd0, timeout}, 8'h00);
        @(negedge clk);
        rst = 1'b0;

        // single requester, release pulse
        cycle(1'b0, 8'h01);
        chk("first_grant", gnt, 8'h01);
        cycle(1'b1, 8'h01);
        chk("release_dead", gnt, 8'h00);
        cycle(1'b0, 8'h00);
        cycle(1'b0, 8'h00);

        // all requesting, release every 3 owned cycles; last=0 so order starts at 1
        for (int i = 0; i < 9; i++) begin
            cycle(1'b0, 8'hFF);
            exp_idx = (1 + i) % 8;
            chk("rr_order", {5'd0, sel}, 8'(exp_idx));
            cycle(1'b0, 8'hFF);
            cycle(1'b0, 8'hFF);
            cycle(1'b1, 8'hFF);
            chk("rr_dead", gnt, 8'h00);
        end
        cycle(1'b0, 8'h00);

        // hold expiry with a lone requester 5
        cycle(1'b0, 8'h20);
        hold = (gnt == 8'h20) ? 1 : 0;
        for (int i = 0; i < 40; i++) begin
            cycle(1'b0, 8'h20);
            if (gnt != 8'h20) break;
            hold++;
        end
        chk("hold_len", 8'(hold), 8'(MAX_HOLD));
        chk("hold_timeout", {7'd0, timeout}, 8'h01);
        cycle(1'b0, 8'h20);
        chk("regrant5", gnt, 8'h20);
        cycle(1'b1, 8'h20);
        cycle(1'b0, 8'h00);

        // wrap-around 7 -> 0, then owner 0 drops its request
        cycle(1'b0, 8'h80);
        chk("grant7", gnt, 8'h80);
        cycle(1'b1, 8'h81);
        cycle(1'b0, 8'h81);
        chk("wrap_to0", gnt, 8'h01);
        cycle(1'b0, 8'h80);
        chk("drop_switch", gnt, 8'h00);
        cycle(1'b0, 8'h80);
        chk("regrant7", gnt, 8'h80);

        // release coincident with hold expiry: no timeout pulse
        for (int i = 0; i < MAX_HOLD - 1; i++) cycle(1'b0, 8'h80);
        cycle(1'b1, 8'h80);
        chk("rel_expiry_gnt", gnt, 8'h00);
        chk("rel_expiry_to", {7'd0, timeout}, 8'h00);
        cycle(1'b0, 8'h00);

        // asynchronous reset in the middle of an ownership
        cycle(1'b0, 8'h08);
        cycle(1'b0, 8'h08);
        chk("pre_rst_gnt", gnt, 8'h08);
        #1;
        rst = 1'b1;
        #1;
        chk("async_gnt", gnt, 8'h00);
        chk("async_sel", {5'd0, sel}, 8'h00);
        chk("async_busy", {7'd0, busy}, 8'h00);
        model_reset();
        req = 8'h0C;
        @(posedge clk);
        #2;
        rst = 1'b0;
        cycle(1'b0, 8'h0C);
        chk("post_rst_grant2", {5'd0, sel}, 8'd2);
        cycle(1'b1, 8'h0C);
        cycle(1'b0, 8'h00);
        chk("sb_drained", 8'(sb.size()), 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
